// File: rtl/input_feature_fetch_sequencer.sv
// Input feature fetch sequencer: walks channel, batch row and column,
// and issues one input BRAM read request per data point.
module input_feature_fetch_sequencer #(
  parameter int INPUT_CHANNEL_WIDTH    = 8,
  parameter int INPUT_ROW_WIDTH        = 6,
  parameter int INPUT_COL_WIDTH        = 6,
  parameter int INPUT_BRAM_DEPTH       = 50176,
  parameter int INPUT_BRAM_DEPTH_WIDTH = $clog2(INPUT_BRAM_DEPTH)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [INPUT_CHANNEL_WIDTH-1:0]    i_num_channel,
  input  logic [INPUT_ROW_WIDTH-1:0]        i_start_index_batch_row,
  input  logic [INPUT_ROW_WIDTH-1:0]        i_end_index_batch_row,
  input  logic [INPUT_COL_WIDTH-1:0]        i_num_col,
  input  logic                              i_req_ready,
  output logic                              o_req_valid,
  output logic [INPUT_BRAM_DEPTH_WIDTH-1:0] o_req_addr,
  output logic [INPUT_CHANNEL_WIDTH-1:0]    o_channel_data_point,
  output logic [INPUT_ROW_WIDTH-1:0]        o_row_data_point,
  output logic [INPUT_COL_WIDTH-1:0]        o_col_data_point,
  output logic                              o_req_last,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int CW = INPUT_CHANNEL_WIDTH;
  localparam int RW = INPUT_ROW_WIDTH;
  localparam int LW = INPUT_COL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state;

  logic [CW-1:0] num_ch_q;
  logic [RW-1:0] start_q;
  logic [RW-1:0] end_q;
  logic [LW-1:0] num_col_q;

  logic          xfer;
  logic          col_wrap;
  logic          row_wrap;
  logic [CW-1:0] ch_n;
  logic [RW-1:0] row_n;
  logic [LW-1:0] col_n;
  logic          last_n;
  logic          degen;
  logic          first_last;

  // Next coordinates after a transfer and job classification at start
  always_comb begin
    xfer       = o_req_valid & i_req_ready;
    col_wrap   = o_col_data_point == num_col_q - LW'(1);
    row_wrap   = o_row_data_point == end_q;
    col_n      = col_wrap ? '0 : o_col_data_point + LW'(1);
    row_n      = o_row_data_point;
    ch_n       = o_channel_data_point;
    if (col_wrap) begin
      row_n = row_wrap ? start_q : o_row_data_point + RW'(1);
      if (row_wrap) begin
        ch_n = o_channel_data_point + CW'(1);
      end
    end
    last_n     = (ch_n == num_ch_q - CW'(1)) &&
                 (row_n == end_q) &&
                 (col_n == num_col_q - LW'(1));
    degen      = (i_num_channel == '0) ||
                 (i_num_col == '0) ||
                 (i_end_index_batch_row < i_start_index_batch_row);
    first_last = (i_num_channel == CW'(1)) &&
                 (i_num_col == LW'(1)) &&
                 (i_end_index_batch_row == i_start_index_batch_row);
  end

  // Control FSM with registered request payload and status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= S_IDLE;
      num_ch_q             <= '0;
      start_q              <= '0;
      end_q                <= '0;
      num_col_q            <= '0;
      o_req_valid          <= 1'b0;
      o_req_addr           <= '0;
      o_channel_data_point <= '0;
      o_row_data_point     <= '0;
      o_col_data_point     <= '0;
      o_req_last           <= 1'b0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          o_req_valid <= 1'b0;
          o_busy      <= 1'b0;
          o_done      <= 1'b0;
          if (i_start) begin
            num_ch_q             <= i_num_channel;
            start_q              <= i_start_index_batch_row;
            end_q                <= i_end_index_batch_row;
            num_col_q            <= i_num_col;
            o_req_addr           <= '0;
            o_channel_data_point <= '0;
            o_row_data_point     <= i_start_index_batch_row;
            o_col_data_point     <= '0;
            o_busy               <= 1'b1;
            if (degen) begin
              state      <= S_DONE;
              o_done     <= 1'b1;
              o_req_last <= 1'b0;
            end else begin
              state       <= S_ISSUE;
              o_req_valid <= 1'b1;
              o_req_last  <= first_last;
            end
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            o_req_addr <= o_req_addr + 1'b1;
            if (o_req_last) begin
              state       <= S_DONE;
              o_req_valid <= 1'b0;
              o_req_last  <= 1'b0;
              o_done      <= 1'b1;
            end else begin
              o_channel_data_point <= ch_n;
              o_row_data_point     <= row_n;
              o_col_data_point     <= col_n;
              o_req_last           <= last_n;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_feature_fetch_sequencer.sv
// Testbench for input_feature_fetch_sequencer: table vectors, corner
// sequences and randomized jobs against a nested-loop reference model.
module tb_input_feature_fetch_sequencer;

  localparam int CW = 8;
  localparam int RW = 6;
  localparam int LW = 6;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] nch = '0;
  logic [RW-1:0] rs_i = '0;
  logic [RW-1:0] re_i = '0;
  logic [LW-1:0] ncol = '0;
  logic          ready = 1'b0;

  logic          o_req_valid;
  logic [AW-1:0] o_req_addr;
  logic [CW-1:0] o_ch;
  logic [RW-1:0] o_row;
  logic [LW-1:0] o_col;
  logic          o_req_last;
  logic          o_busy;
  logic          o_done;

  input_feature_fetch_sequencer dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_start                 (start),
    .i_num_channel           (nch),
    .i_start_index_batch_row (rs_i),
    .i_end_index_batch_row   (re_i),
    .i_num_col               (ncol),
    .i_req_ready             (ready),
    .o_req_valid             (o_req_valid),
    .o_req_addr              (o_req_addr),
    .o_channel_data_point    (o_ch),
    .o_row_data_point        (o_row),
    .o_col_data_point        (o_col),
    .o_req_last              (o_req_last),
    .o_busy                  (o_busy),
    .o_done                  (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] ch;
    logic [RW-1:0] row;
    logic [LW-1:0] col;
    logic          last;
  } req_t;

  typedef struct {
    int ch;
    int rs;
    int re;
    int nc;
    int mode;
    bit inject;
    int exp_n;
    int exp_last;
  } vec_t;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] pack(input req_t r);
    return 64'({r.addr, r.ch, r.row, r.col, r.last});
  endfunction

  function automatic logic [63:0] dut_payload();
    return 64'({o_req_addr, o_ch, o_row, o_col, o_req_last});
  endfunction

  function automatic logic [63:0] dut_all();
    return 64'({o_req_valid, o_req_addr, o_ch, o_row, o_col,
                o_req_last, o_busy, o_done});
  endfunction

  task automatic run_job(input int c, input int s, input int e,
                         input int n, input int mode, input bit inject,
                         output int nx, output int la);
    req_t q[$];
    req_t r;
    int   rows;
    int   k;
    int   last_cyc;
    bit   seen;
    bit   rdy;
    rows = e - s + 1;
    q = {};
    if (c > 0 && n > 0 && rows > 0) begin
      for (int ci = 0; ci < c; ci++)
        for (int ri = s; ri <= e; ri++)
          for (int co = 0; co < n; co++) begin
            r.addr = AW'(ci * rows * n + (ri - s) * n + co);
            r.ch   = CW'(ci);
            r.row  = RW'(ri);
            r.col  = LW'(co);
            r.last = (q.size() == c * rows * n - 1);
            q.push_back(r);
          end
    end
    nx = 0;
    la = 0;
    k = 0;
    seen = 1'b0;
    last_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    nch   = CW'(c);
    rs_i  = RW'(s);
    re_i  = RW'(e);
    ncol  = LW'(n);
    ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
      nch  = CW'($urandom);
      rs_i = RW'($urandom);
      re_i = RW'($urandom);
      ncol = LW'($urandom);
      if (o_done) begin
        seen = 1'b1;
        chk("done_timing", 64'(cyc), 64'(last_cyc + 1));
        chk("done_valid", 64'(o_req_valid), 64'd0);
        chk("done_busy", 64'(o_busy), 64'd1);
      end else begin
        if (o_req_valid) begin
          chk("busy", 64'(o_busy), 64'd1);
          if (k < q.size()) chk("payload", dut_payload(), pack(q[k]));
          else chk("extra_req", 64'(k), 64'(q.size()));
          case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
          endcase
          if (rdy) begin
            k++;
            nx++;
            la = int'(o_req_addr);
            last_cyc = cyc;
          end
        end else begin
          rdy = 1'($urandom_range(0, 1));
          chk("active", 64'(o_req_valid | o_done), 64'd1);
        end
        ready = rdy;
        start = inject && (cyc == 3);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) chk("timeout", 64'd0, 64'd1);
    chk("count", 64'(k), 64'(q.size()));
    @(negedge clk);
    chk("idle_done", 64'(o_done), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_valid", 64'(o_req_valid), 64'd0);
    ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int nx;
    int la;
    int xf;
    int c;
    int s;
    int e;
    int n;

    vecs[0] = '{2, 3, 4, 3, 0, 1'b0, 12, 11};
    vecs[1] = '{2, 3, 4, 3, 1, 1'b0, 12, 11};
    vecs[2] = '{2, 3, 4, 0, 0, 1'b0, 0, 0};
    vecs[3] = '{2, 5, 4, 3, 0, 1'b0, 0, 0};
    vecs[4] = '{1, 7, 7, 1, 0, 1'b0, 1, 0};
    vecs[5] = '{2, 3, 4, 3, 0, 1'b1, 12, 11};
    vecs[6] = '{3, 10, 12, 4, 2, 1'b1, 36, 35};
    vecs[7] = '{0, 1, 2, 3, 0, 1'b0, 0, 0};

    #12;
    chk("reset_outputs", dut_all(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", dut_all(), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].ch, vecs[i].rs, vecs[i].re, vecs[i].nc,
              vecs[i].mode, vecs[i].inject, nx, la);
      chk("vec_count", 64'(nx), 64'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0)
        chk("vec_last_addr", 64'(la), 64'(vecs[i].exp_last));
    end

    // Reset in the middle of a job
    @(negedge clk);
    start = 1'b1;
    nch   = 8'd2;
    rs_i  = 6'd3;
    re_i  = 6'd4;
    ncol  = 6'd3;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
    xf = 0;
    for (int cyc = 0; cyc < 50 && xf < 5; cyc++) begin
      if (o_req_valid) xf++;
      @(negedge clk);
    end
    chk("mid_xfers", 64'(xf), 64'd5);
    chk("mid_addr", 64'(o_req_addr), 64'd5);
    #2 rst = 1'b1;
    #1 chk("async_reset", dut_all(), 64'd0);
    @(negedge clk);
    chk("reset_no_done", 64'(o_done), 64'd0);
    rst = 1'b0;
    ready = 1'b0;
    run_job(2, 3, 4, 3, 0, 1'b0, nx, la);
    chk("post_reset_count", 64'(nx), 64'd12);

    for (int j = 0; j < 25; j++) begin
      c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
      s = int'($urandom_range(0, 58));
      e = s + int'($urandom_range(0, 4)) - 1;
      if (e < 0) e = 0;
      n = int'($urandom_range(0, 5));
      run_job(c, s, e, n, 2, 1'($urandom_range(0, 1)), nx, la);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
